multi_channel_clock_divider: RTL and testbench
==============================================

Name: multi_channel_clock_divider

Overview:
Parametrised successor to the fixed 50-to-5 MHz divider. Provides NUM_CH independent divided-clock channels from one system clock, each with an exact runtime divisor, duty cycle and enable. Each channel also has a one-cycle period Tick strobe for use as a clock enable.
New divisor and duty settings load through a valid/ready handshake and take effect only at a period boundary, so outputs never glitch.

Parameters:
NUM_CH, 2, number of independent channels (1..16)
CNT_W, 16, counter, divisor and high-time width
DEFAULT_DIV, 10, divisor after reset (>=2)
CH_W, $clog2(NUM_CH) min 1, LoadCh width (derived, localparam)

Ports:
ClockIn  in  1  system clock, all logic on rising edge
Resetn  in  1  synchronous, active-low reset
Enable  in  NUM_CH  per-channel run enable
LoadValid  in  1  load request valid
LoadReady  out  1  load can be accepted this cycle
LoadCh  in  CH_W  target channel of load
LoadDiv  in  CNT_W  new divisor (period in ClockIn cycles)
LoadHigh  in  CNT_W  new high time in ClockIn cycles
ClkOut  out  NUM_CH  divided clock outputs (registered)
Tick  out  NUM_CH  one-cycle strobe at last cycle of each period (registered)

Behaviour:
- Reset (Resetn=0 at edge): per channel cnt=0, div=DEFAULT_DIV, high=DEFAULT_DIV/2, pending=0; ClkOut=0, Tick=0. Reset mid-period or mid-load discards all pending loads.
- LoadReady is combinational: !pending[LoadCh]. It is 1 when LoadCh >= NUM_CH; the load is then accepted and dropped.
- Transfer occurs when LoadValid && LoadReady at an edge. Shadow div/high of LoadCh are written and pending is set.
- Load sanitising at acceptance: LoadDiv<2 is stored as 2. LoadHigh is stored unchanged.
- Per channel, at each edge with Enable=1:
  ClkOut <= (cnt < high); Tick <= (cnt == div-1)
  cnt <= (cnt == div-1) ? 0 : cnt+1
  When cnt == div-1 and pending: div/high <= shadow and pending <= 0 on the same edge. The next period uses the new values.
- The output lags the counter by one cycle. The first ClkOut high appears the edge after Enable is first sampled 1.
- Duty extremes: high=0 gives ClkOut constantly 0. high>=div gives ClkOut constantly 1. Tick runs normally in both cases.
- A load accepted on the same edge as a boundary is not applied at that boundary. It waits for the next boundary, because pending is sampled pre-edge.
- Enable=0 at edge: cnt<=0, ClkOut<=0, Tick<=0. Any pending load is applied immediately and pending is cleared.
- Enable is re-sampled every cycle. Dropping Enable mid-period truncates the period. No partial Tick is issued.
- Counter arithmetic is unsigned, CNT_W bits. The maximum divisor is 2^CNT_W-1. The cnt+1 never overflows because cnt < div.
- Channels are fully independent. Only the load bus is shared, one load per cycle.

Decomposition:
- Package clkdiv_pkg: DEFAULT_DIV, MIN_DIV=2, CH_W derivation function, and a typedef for the {div, high} pair.
- Sub-module clock_divider_channel holds one channel's counter, active/shadow registers, pending flag and output registers. The top module instantiates NUM_CH copies and does load decode/ready muxing.

Test Plan:
1. Reset, Enable[0]=1, defaults: ClkOut[0] period exactly 10 cycles, 5 high/5 low; Tick[0] 1 cycle every 10, coincident with last low cycle.
2. Load ch0 Div=7 High=2 mid-period: current 10-cycle period completes unchanged, then 7-cycle periods with 2 high. LoadReady(ch0) low until boundary; second load stalls then accepts.
3. Load Div=0 High=0 then Div=4 High=9: first gives ClkOut constant 0 and Tick every 2 cycles; second gives ClkOut constant 1 and Tick every 4 cycles.
4. Load accepted exactly on cnt==div-1 edge: old values used for one more full period, new values after.
5. Enable[1] dropped at cnt=3 with load pending, then re-raised: ClkOut/Tick 0 next edge, new div applied, restart at cnt=0, no stray Tick. Ch0 is unaffected.
6. Resetn low mid-period with pending load, LoadCh=NUM_CH load: all outputs 0, defaults restored, pending cleared. The out-of-range load is accepted (LoadReady=1) with no effect.

Source files
------------

// File: rtl/multi_channel_clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int DEFAULT_DIV = 10;
  localparam int MIN_DIV     = 2;

  // A single channel still needs a one-bit channel select.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/multi_channel_clock_divider_if.sv
// Shared load bus: one {channel, divisor, high time} transfer per cycle.
interface multi_channel_clock_divider_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  localparam int CH_W = clkdiv_pkg::ch_width(NUM_CH);

  logic             LoadValid;
  logic             LoadReady;
  logic [CH_W-1:0]  LoadCh;
  logic [CNT_W-1:0] LoadDiv;
  logic [CNT_W-1:0] LoadHigh;

  modport master (output LoadValid, LoadCh, LoadDiv, LoadHigh, input LoadReady);
  modport slave  (input LoadValid, LoadCh, LoadDiv, LoadHigh, output LoadReady);

endinterface

// File: rtl/multi_channel_clock_divider_channel.sv
// One divider channel: counter, active/shadow {div, high}, pending flag and
// registered ClkOut/Tick. Shadow values move to active only at a period end.
module clock_divider_channel #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic [CNT_W-1:0] load_high,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);
  import clkdiv_pkg::*;

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
  } cfg_t;

  localparam cfg_t RST_CFG = '{div: CNT_W'(DEFAULT_DIV), high: CNT_W'(DEFAULT_DIV / 2)};

  cfg_t             act;
  cfg_t             shadow;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             apply;

  assign last  = (cnt == act.div - 1'b1);
  // A disabled channel has no period to protect, so it takes the update at once.
  assign apply = pending && (!en || last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      act     <= RST_CFG;
      shadow  <= RST_CFG;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      // load only arrives while !pending and apply needs pending: never both.
      if (load) begin
        shadow.div  <= (load_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : load_div;
        shadow.high <= load_high;
        pending     <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end

      if (apply) act <= shadow;

      if (en) begin
        clk_out <= (cnt < act.high);
        tick    <= last;
        cnt     <= last ? '0 : cnt + 1'b1;
      end else begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent runtime-programmable clock dividers sharing one load bus.
module multi_channel_clock_divider #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV
) (
  input  logic                      ClockIn,
  input  logic                      Resetn,
  input  logic [NUM_CH-1:0]         Enable,
  multi_channel_clock_divider_if.slave load,
  output logic [NUM_CH-1:0]         ClkOut,
  output logic [NUM_CH-1:0]         Tick
);
  import clkdiv_pkg::*;

  localparam int CH_W    = ch_width(NUM_CH);
  localparam int CH_SPAN = 1 << CH_W;

  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  ch_load;
  logic [CH_SPAN-1:0] pending_span;
  logic               accept;

  // Unused channel codes read as never-pending, so out-of-range loads are
  // accepted and simply decode to no channel.
  always_comb begin
    pending_span               = '0;
    pending_span[NUM_CH-1:0]   = pending;
  end

  assign load.LoadReady = !pending_span[load.LoadCh];
  assign accept         = load.LoadValid && load.LoadReady;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_load[i] = accept && (load.LoadCh == CH_W'(i));

    clock_divider_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (ClockIn),
      .rst_n     (Resetn),
      .en        (Enable[i]),
      .load      (ch_load[i]),
      .load_div  (load.LoadDiv),
      .load_high (load.LoadHigh),
      .pending   (pending[i]),
      .clk_out   (ClkOut[i]),
      .tick      (Tick[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed bench: per-cycle ClkOut/Tick/LoadReady traces compared against
// hand-derived waveform strings, plus hand sequences for stall and reset.
module tb_multi_channel_clock_divider;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;

  logic              ClockIn = 1'b0;
  logic              Resetn;
  logic [NUM_CH-1:0] Enable;
  logic [NUM_CH-1:0] ClkOut;
  logic [NUM_CH-1:0] Tick;

  multi_channel_clock_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) lif ();

  multi_channel_clock_divider #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (10)
  ) dut (
    .ClockIn (ClockIn),
    .Resetn  (Resetn),
    .Enable  (Enable),
    .load    (lif),
    .ClkOut  (ClkOut),
    .Tick    (Tick)
  );

  always #5 ClockIn = ~ClockIn;

  // One row: inputs held for len(clk) cycles (LoadValid only for the first),
  // with the expected per-cycle trace of channel ch and of LoadReady.
  typedef struct {
    string             name;
    logic [NUM_CH-1:0] en;
    logic              lv;
    logic [1:0]        lch;
    logic [CNT_W-1:0]  ldiv;
    logic [CNT_W-1:0]  lhigh;
    int                ch;
    string             clk;
    string             tick;
    string             rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input string name, input int en, input int lv, input int lch,
                              input int ldiv, input int lhigh, input int ch,
                              input string clk, input string tick, input string rdy);
    vec_t v;
    v.name  = name;
    v.en    = NUM_CH'(en);
    v.lv    = lv[0];
    v.lch   = 2'(lch);
    v.ldiv  = CNT_W'(ldiv);
    v.lhigh = CNT_W'(lhigh);
    v.ch    = ch;
    v.clk   = clk;
    v.tick  = tick;
    v.rdy   = rdy;
    vecs.push_back(v);
  endfunction

  function automatic string b2s(input logic b);
    return (b === 1'b1) ? "1" : "0";
  endfunction

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      string c, t, y;
      c = ""; t = ""; y = "";
      Enable        = vecs[r].en;
      lif.LoadValid = vecs[r].lv;
      lif.LoadCh    = vecs[r].lch;
      lif.LoadDiv   = vecs[r].ldiv;
      lif.LoadHigh  = vecs[r].lhigh;
      for (int i = 0; i < vecs[r].clk.len(); i++) begin
        #1;
        y = {y, b2s(lif.LoadReady)};
        @(posedge ClockIn);
        #1;
        lif.LoadValid = 1'b0;
        c = {c, b2s(ClkOut[vecs[r].ch])};
        t = {t, b2s(Tick[vecs[r].ch])};
      end
      check_str({vecs[r].name, ".clk"},  c, vecs[r].clk);
      check_str({vecs[r].name, ".tick"}, t, vecs[r].tick);
      check_str({vecs[r].name, ".rdy"},  y, vecs[r].rdy);
    end
  endtask

  initial begin
    int stall;
    int done;

    Resetn        = 1'b0;
    Enable        = '0;
    lif.LoadValid = 1'b0;
    lif.LoadCh    = '0;
    lif.LoadDiv   = '0;
    lif.LoadHigh  = '0;

    //   name                en  lv ch div high obs clk / tick / ready traces
    add("default_div10",     1, 0, 0, 0, 0, 0, "11111000001111100000", "00000000010000000001", "11111111111111111111");
    add("pre_load",          1, 0, 0, 0, 0, 0, "111", "000", "111");
    add("load_7_2_mid",      1, 1, 0, 7, 2, 0, "110000011000001100000", "000000100000010000001", "100000011111111111111");
    add("div2_high0",        1, 0, 0, 0, 0, 0, "000000", "101010", "011111");
    add("load_4_9",          1, 1, 0, 4, 9, 0, "00011111111", "10100010001", "10011111111");
    add("lead_in",           1, 0, 0, 0, 0, 0, "111", "000", "111");
    add("load_on_boundary",  1, 1, 0, 3, 1, 0, "11111100100", "10001001001", "10000111111");
    add("ch1_start",         3, 0, 1, 0, 0, 1, "11", "00", "11");
    add("ch1_load",          3, 1, 1, 6, 3, 1, "1", "0", "1");
    add("ch1_disable",       1, 0, 1, 0, 0, 1, "000", "000", "011");
    add("ch1_restart",       3, 0, 1, 0, 0, 1, "111000111000", "000001000001", "111111111111");
    add("ch0_phase",         3, 0, 0, 0, 0, 0, "100100", "001001", "111111");
    add("ch0_pend",          3, 1, 0, 5, 4, 0, "10", "00", "10");
    add("after_reset",       1, 0, 0, 0, 0, 0, "11111000001111100000", "00000000010000000001", "11111111111111111111");

    repeat (3) @(posedge ClockIn);
    #1;
    check_val("rst_clkout", int'(ClkOut), 0);
    check_val("rst_tick",   int'(Tick), 0);
    check_val("rst_ready",  int'(lif.LoadReady), 1);

    Resetn = 1'b1;
    run_rows(0, 2);

    // Two back-to-back loads: the second waits out the first's pending period.
    Enable        = 3'b001;
    lif.LoadCh    = 2'd0;
    lif.LoadDiv   = '0;
    lif.LoadHigh  = '0;
    lif.LoadValid = 1'b1;
    #1;
    check_val("stall_first_ready", int'(lif.LoadReady), 1);
    @(posedge ClockIn);
    #1;
    stall = 0;
    done  = 0;
    for (int k = 0; k < 50 && done == 0; k++) begin
      #1;
      if (lif.LoadReady) done = 1;
      else stall++;
      @(posedge ClockIn);
      #1;
    end
    lif.LoadValid = 1'b0;
    check_val("stall_accepted", done, 1);
    check_val("stall_cycles", stall, 6);

    run_rows(3, 12);

    // Reset with ch0 load pending and ch1 high, then an out-of-range load.
    Enable = '0;
    Resetn = 1'b0;
    @(posedge ClockIn);
    #1;
    check_val("midrst_clkout", int'(ClkOut), 0);
    check_val("midrst_tick",   int'(Tick), 0);
    lif.LoadCh = 2'd0;
    #1;
    check_val("midrst_ready_ch0", int'(lif.LoadReady), 1);
    Resetn        = 1'b1;
    lif.LoadCh    = 2'd3;
    lif.LoadDiv   = 16'd3;
    lif.LoadHigh  = 16'd1;
    lif.LoadValid = 1'b1;
    #1;
    check_val("oor_ready", int'(lif.LoadReady), 1);
    @(posedge ClockIn);
    #1;
    lif.LoadValid = 1'b0;
    check_val("oor_clkout", int'(ClkOut), 0);

    run_rows(13, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
